// File: rtl/computer_pkg.sv
// Shared types and constants for the CPU/VDP memory bus slot scheduler.
package computer_pkg;

    typedef enum logic {SLOT_CPU, SLOT_VID} slot_t;

    typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_NONE} region_t;

    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decoder: classifies a bus address as RAM, ROM or unmapped.
module mem_region_decode
    import computer_pkg::*;
#(
    parameter logic [15:0] RAM_TOP  = 16'h7FFF,
    parameter logic [15:0] ROM_BASE = 16'hE000
) (
    input  logic [15:0] adr,
    output region_t     region
);

    always_comb begin
        region = REG_NONE;
        if (adr <= RAM_TOP) begin
            region = REG_RAM;
        end else if (adr >= ROM_BASE) begin
            region = REG_ROM;
        end
    end

endmodule

// File: rtl/mem_slot_scheduler.sv
// Time-slot arbiter sharing one memory bus between the 6502 and the VDP,
// alternating CPU and VID slots of PHASES cycles and issuing the CPU clock-enable.
module mem_slot_scheduler
    import computer_pkg::*;
#(
    parameter int          PHASES   = 4,
    parameter logic [15:0] RAM_TOP  = 16'h7FFF,
    parameter logic [15:0] ROM_BASE = 16'hE000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [15:0] cpu_adr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_dbo,
    input  logic        cpu_halt,
    output logic        cpu_ce,
    output logic [7:0]  cpu_dbi,
    input  logic        vid_req,
    input  logic [15:0] vid_adr,
    output logic        vid_ack,
    output logic [7:0]  vid_data,
    output logic [15:0] mem_adr,
    output logic        mem_en,
    output logic        ram_we,
    input  logic [7:0]  ram_q,
    input  logic [7:0]  rom_q,
    output logic        slot
);

    localparam int            PW      = $clog2(PHASES);
    localparam logic [PW-1:0] LAST    = PW'(PHASES - 1);
    localparam logic [PW-1:0] CE_PREP = PW'(PHASES - 2);

    logic [PW-1:0] phase, phase_next;
    slot_t         slot_q, slot_next;
    logic [15:0]   acc_adr;
    region_t       acc_region, region_q;
    logic          starting, cpu_start, vid_start, acc_read;
    logic          mem_en_q, ram_we_q, cpu_ce_q, vid_ack_q;
    logic [7:0]    rd_data;
    logic          unused_dbo;

    // Write data runs straight from the CPU to the RAM; only the strobe is timed here.
    assign unused_dbo = ^cpu_dbo;

    always_comb begin
        phase_next = phase + PW'(1);
        slot_next  = slot_q;
        if (phase == LAST) begin
            phase_next = '0;
            slot_next  = (slot_q == SLOT_CPU) ? SLOT_VID : SLOT_CPU;
        end
    end

    // Address mux selects the master owning the slot about to begin.
    assign starting  = (phase == LAST);
    assign cpu_start = starting && (slot_next == SLOT_CPU);
    assign vid_start = starting && (slot_next == SLOT_VID) && vid_req;
    assign acc_adr   = (slot_next == SLOT_CPU) ? cpu_adr : vid_adr;

    mem_region_decode #(
        .RAM_TOP  (RAM_TOP),
        .ROM_BASE (ROM_BASE)
    ) u_decode (
        .adr    (acc_adr),
        .region (acc_region)
    );

    always_comb begin
        rd_data = UNMAPPED_DATA;
        case (region_q)
            REG_RAM: rd_data = ram_q;
            REG_ROM: rd_data = rom_q;
            default: rd_data = UNMAPPED_DATA;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            phase     <= '0;
            slot_q    <= SLOT_CPU;
            mem_adr   <= '0;
            mem_en_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            region_q  <= REG_NONE;
            acc_read  <= 1'b0;
            cpu_ce_q  <= 1'b0;
            vid_ack_q <= 1'b0;
            cpu_dbi   <= UNMAPPED_DATA;
            vid_data  <= 8'h00;
        end else begin
            phase     <= phase_next;
            slot_q    <= slot_next;
            mem_en_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            cpu_ce_q  <= 1'b0;
            vid_ack_q <= 1'b0;
            if (starting) begin
                acc_read <= cpu_start ? cpu_rw : vid_start;
            end
            if (cpu_start || vid_start) begin
                mem_adr  <= acc_adr;
                mem_en_q <= 1'b1;
                region_q <= acc_region;
                ram_we_q <= cpu_start && !cpu_rw && (acc_region == REG_RAM);
            end
            // Sync memory data is valid during p1; capture it on the edge ending p1.
            if (phase == PW'(1) && acc_read) begin
                if (slot_q == SLOT_CPU) begin
                    cpu_dbi <= rd_data;
                end else begin
                    vid_data  <= rd_data;
                    vid_ack_q <= 1'b1;
                end
            end
            if (phase == CE_PREP && slot_q == SLOT_CPU && !cpu_halt) begin
                cpu_ce_q <= 1'b1;
            end
        end
    end

    // Strobes are masked by reset so an access already set up is dropped at once.
    assign mem_en  = mem_en_q  && !reset;
    assign ram_we  = ram_we_q  && !reset;
    assign cpu_ce  = cpu_ce_q  && !reset;
    assign vid_ack = vid_ack_q && !reset;
    assign slot    = (slot_q == SLOT_VID);

endmodule

// File: tb/tb_mem_slot_scheduler.sv
// Randomized self-checking bench for mem_slot_scheduler against a slot-level model.
module tb_mem_slot_scheduler;

    localparam int P    = 4;
    localparam int NDIR = 11;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] cpu_adr  = '0;
    logic        cpu_rw   = 1'b1;
    logic [7:0]  cpu_dbo  = '0;
    logic        cpu_halt = 1'b0;
    logic        vid_req  = 1'b0;
    logic [15:0] vid_adr  = '0;
    logic [7:0]  ram_q    = '0;
    logic [7:0]  rom_q    = '0;
    logic        cpu_ce, vid_ack, mem_en, ram_we, slot;
    logic [7:0]  cpu_dbi, vid_data;
    logic [15:0] mem_adr;

    always #10 CLOCK_50 = ~CLOCK_50;

    mem_slot_scheduler #(.PHASES(P)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .cpu_adr  (cpu_adr),
        .cpu_rw   (cpu_rw),
        .cpu_dbo  (cpu_dbo),
        .cpu_halt (cpu_halt),
        .cpu_ce   (cpu_ce),
        .cpu_dbi  (cpu_dbi),
        .vid_req  (vid_req),
        .vid_adr  (vid_adr),
        .vid_ack  (vid_ack),
        .vid_data (vid_data),
        .mem_adr  (mem_adr),
        .mem_en   (mem_en),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .rom_q    (rom_q),
        .slot     (slot)
    );

    function automatic logic [7:0] ramInit(input int i);
        return 8'(i * 37 + 11);
    endfunction

    function automatic logic [7:0] romByte(input logic [15:0] a);
        return a[7:0] ^ 8'hFC;
    endfunction

    // Synchronous RAM and ROM behind the shared bus.
    logic [7:0] ramMem [0:32767];
    bit         memInit = 1'b0;
    always @(posedge CLOCK_50) begin
        if (!memInit) begin
            for (int i = 0; i < 32768; i++) ramMem[i] <= ramInit(i);
            memInit <= 1'b1;
        end else if (mem_en) begin
            ram_q <= ramMem[mem_adr[14:0]];
            rom_q <= romByte(mem_adr);
            if (ram_we) ramMem[mem_adr[14:0]] <= cpu_dbo;
        end
    end

    logic [7:0]  shadow [0:32767];
    logic [15:0] dirAdr [NDIR] = '{16'h0010, 16'h0010, 16'hFFFC, 16'h9000, 16'hE000, 16'h7FFF,
                                   16'h7FFF, 16'h8000, 16'hDFFF, 16'hDFFF, 16'h0020};
    logic        dirRw  [NDIR] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  dirDbo [NDIR] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h33, 8'h77, 8'h00, 8'h00,
                                   8'h11, 8'h00, 8'h00};

    int          checks = 0, errors = 0;
    int          t = 0, opIdx = 0, haltFrom = 30, rstSlot = -1;
    int          vidServe = 0, vidAckAt = 0, vidGap = 2 * P + 1, vidRaise = 0;
    logic [15:0] curAdr = '0, vidAdr = '0, expMemAdr = '0;
    logic        curRw = 1'b1, curHalt = 1'b0;
    logic [7:0]  curDbo = '0, expCpuDbi = 8'hFF, expVidData = 8'h00;
    bit          vidPending = 0, firstVid = 1, allowVid = 0, haltWindow = 0;
    bit          rstArm = 0, rstFired = 0, skipWait = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0d got=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [7:0] modelRead(input logic [15:0] a);
        if (a < 16'h8000) return shadow[a[14:0]];
        if (a >= 16'hE000) return romByte(a);
        return 8'hFF;
    endfunction

    function automatic logic [15:0] randAdr();
        logic [15:0] a;
        case ($urandom_range(0, 5))
            0, 1:    a = 16'($urandom_range(0, 63));
            2:       a = 16'($urandom_range(32'hE000, 32'hFFFF));
            3:       a = 16'($urandom_range(32'h8000, 32'hDFFF));
            4:       a = 16'h7FC0 + 16'($urandom_range(0, 63));
            default: begin
                case ($urandom_range(0, 3))
                    0:       a = 16'h7FFF;
                    1:       a = 16'h8000;
                    2:       a = 16'hDFFF;
                    default: a = 16'hE000;
                endcase
            end
        endcase
        return a;
    endfunction

    task automatic nextCpuOp(input int k);
        if (rstArm && rstSlot < 0) begin
            curAdr = 16'h0020; curRw = 1'b0; curDbo = 8'h5A; rstSlot = k + 2;
        end else if (opIdx < NDIR) begin
            curAdr = dirAdr[opIdx]; curRw = dirRw[opIdx]; curDbo = dirDbo[opIdx];
            opIdx++;
        end else begin
            curAdr = randAdr(); curRw = 1'($urandom_range(0, 1)); curDbo = 8'($urandom);
        end
        cpu_adr = curAdr; cpu_rw = curRw; cpu_dbo = curDbo;
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(negedge CLOCK_50); #1;
            checkOutput("rst_mem_en", mem_en, 0);
            checkOutput("rst_ram_we", ram_we, 0);
            checkOutput("rst_cpu_ce", cpu_ce, 0);
            checkOutput("rst_vid_ack", vid_ack, 0);
        end
        reset = 1'b0;
        t = 0; skipWait = 1; rstSlot = -1; vidPending = 0; vid_req = 1'b0;
        expCpuDbi = 8'hFF; expVidData = 8'h00; expMemAdr = '0; curHalt = 1'b0; cpu_halt = 1'b0;
    endtask

    // One bus cycle: predict from slot arithmetic, compare, then drive the masters.
    task automatic applyStimulus();
        int p, k;
        bit isCpu, expEn, expWe, expCe, expAck;
        if (skipWait) begin
            skipWait = 0; #1;
        end else begin
            @(negedge CLOCK_50); #1;
        end
        p = t % P; k = t / P; isCpu = (k % 2) == 0;
        expEn = 0; expWe = 0;
        if (p == 0 && isCpu && k >= 2) begin
            expEn = 1; expMemAdr = curAdr;
            expWe = !curRw && (curAdr < 16'h8000);
        end
        if (p == 0 && !isCpu && vidPending && k == vidServe) begin
            expEn = 1; expMemAdr = vidAdr;
        end
        if (isCpu && p == 2 && k >= 2 && curRw) expCpuDbi = modelRead(curAdr);
        expAck = vidPending && (t == vidAckAt);
        if (expAck) expVidData = modelRead(vidAdr);
        expCe = isCpu && (p == P - 1) && !curHalt;

        checkOutput("slot", slot, k % 2);
        checkOutput("cpu_ce", cpu_ce, expCe);
        checkOutput("mem_en", mem_en, expEn);
        checkOutput("ram_we", ram_we, expWe);
        checkOutput("mem_adr", mem_adr, expMemAdr);
        checkOutput("cpu_dbi", cpu_dbi, expCpuDbi);
        checkOutput("vid_ack", vid_ack, expAck);
        checkOutput("vid_data", vid_data, expVidData);
        if (vid_ack && vidPending) checkOutput("ack_latency_ok", (t - vidRaise) <= 2 * P + 2, 1);

        if (rstArm && isCpu && p == 0 && k == rstSlot) begin
            reset = 1'b1;
            #1;
            checkOutput("we_in_reset", ram_we, 0);
            checkOutput("en_in_reset", mem_en, 0);
            rstFired = 1;
            return;
        end

        if (expWe) shadow[curAdr[14:0]] = curDbo;
        if (expCe) nextCpuOp(k);
        if (isCpu && p == 0) begin
            curHalt = haltWindow && k >= haltFrom && k < haltFrom + 6;
            cpu_halt = curHalt;
        end
        if (expAck) begin
            vidPending = 0; vid_req = 1'b0;
            vidGap = $urandom_range(0, 12);
            vid_adr = 16'($urandom);
        end else if (!vidPending && allowVid) begin
            if (vidGap > 0) begin
                vidGap--;
            end else begin
                vidAdr = firstVid ? 16'h0400 : randAdr();
                firstVid = 0;
                vid_adr = vidAdr; vid_req = 1'b1;
                vidPending = 1; vidRaise = t;
                vidServe = (t + P) / P;
                if (vidServe % 2 == 0) vidServe++;
                vidAckAt = vidServe * P + 2;
            end
        end
        t++;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) shadow[i] = ramInit(i);
        $display("[TB] starting, PHASES=%0d", P);
        doReset(3);
        allowVid = 1; haltWindow = 1;
        repeat (500) applyStimulus();

        allowVid = 0; haltWindow = 0;
        repeat (4 * P) applyStimulus();

        rstArm = 1;
        for (int i = 0; i < 20 * P && !rstFired; i++) applyStimulus();
        checkOutput("rst_reached", rstFired, 1);
        rstArm = 0;
        doReset(1);
        opIdx = NDIR - 1;
        repeat (8 * P) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
